// File: rtl/csr_llbit_unit.sv
// csr_llbit_unit: execute-side responder for CSRRD/CSRWR/CSRXCHG and LL.W/SC.W.
// Holds CRMD, PRMD, ERA, SAVE0-3, TID, LLBCTL (KLO) and the LLBit. It returns the
// rd writeback through a one-deep registered response slot with valid/ready,
// and applies exception-entry and ERTN side effects.

`ifndef ALU_CSRRD
`define ALU_CSRRD   8'h80
`endif
`ifndef ALU_CSRWR
`define ALU_CSRWR   8'h81
`endif
`ifndef ALU_CSRXCHG
`define ALU_CSRXCHG 8'h82
`endif
`ifndef ALU_LLW
`define ALU_LLW     8'h83
`endif
`ifndef ALU_SCW
`define ALU_SCW     8'h84
`endif

module csr_llbit_unit #(
    parameter logic [31:0] CRMD_RST = 32'h0000_0008,
    parameter logic [31:0] TID_RST  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_aluop,
    input  logic [13:0] req_csr_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_mask,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        sc_success,
    input  logic        excp_valid,
    input  logic [31:0] excp_pc,
    input  logic        ertn_valid,
    input  logic        flush,
    output logic        llbit,
    output logic [1:0]  crmd_plv,
    output logic        crmd_ie,
    output logic [31:0] era_out
);

    localparam logic [13:0] A_CRMD   = 14'h0;
    localparam logic [13:0] A_PRMD   = 14'h1;
    localparam logic [13:0] A_ERA    = 14'h6;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_LLBCTL = 14'h60;

    // CSR state. CRMD keeps only its architected bits [8:0]: PLV[1:0], IE[2], DA.. DATM.
    logic [8:0]  r_crmd;
    logic [2:0]  r_prmd;
    logic [31:0] r_era;
    logic [31:0] r_save0;
    logic [31:0] r_save1;
    logic [31:0] r_save2;
    logic [31:0] r_save3;
    logic [31:0] r_tid;
    logic        r_llbit;
    logic        r_klo;

    // Response slot
    logic        r_resp_valid;
    logic        r_resp_we;
    logic [4:0]  r_resp_rd;
    logic [31:0] r_resp_data;
    logic        r_sc_success;

    logic        w_accept;
    logic        w_is_csr;
    logic        w_is_llw;
    logic        w_is_scw;
    logic        w_csr_we;
    logic [31:0] w_rdata;
    logic [31:0] w_new;

    // Exception/ERTN/flush own the cycle; otherwise accept when the slot frees up.
    assign req_ready = !excp_valid && !ertn_valid && !flush && (!r_resp_valid || resp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_is_csr  = (req_aluop == `ALU_CSRRD) || (req_aluop == `ALU_CSRWR) ||
                       (req_aluop == `ALU_CSRXCHG);
    assign w_is_llw  = (req_aluop == `ALU_LLW);
    assign w_is_scw  = (req_aluop == `ALU_SCW);
    assign w_csr_we  = w_accept && ((req_aluop == `ALU_CSRWR) || (req_aluop == `ALU_CSRXCHG));

    // Read mux: current (old) value of the addressed CSR, 0 for unimplemented numbers.
    always_comb begin
        w_rdata = 32'h0;
        case (req_csr_addr)
            A_CRMD:   w_rdata = {23'h0, r_crmd};
            A_PRMD:   w_rdata = {29'h0, r_prmd};
            A_ERA:    w_rdata = r_era;
            A_SAVE0:  w_rdata = r_save0;
            A_SAVE1:  w_rdata = r_save1;
            A_SAVE2:  w_rdata = r_save2;
            A_SAVE3:  w_rdata = r_save3;
            A_TID:    w_rdata = r_tid;
            A_LLBCTL: w_rdata = {29'h0, r_klo, 1'b0, r_llbit};
            default:  w_rdata = 32'h0;
        endcase
    end

    // Effective new value: full replace for CSRWR, masked merge for CSRXCHG.
    always_comb begin
        w_new = w_rdata;
        if (req_aluop == `ALU_CSRWR) begin
            w_new = req_wdata;
        end else if (req_aluop == `ALU_CSRXCHG) begin
            w_new = (w_rdata & ~req_mask) | (req_wdata & req_mask);
        end
    end

    // CRMD/PRMD/ERA: exception entry wins over ERTN; CSR writes cannot coincide with either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crmd <= CRMD_RST[8:0];
            r_prmd <= 3'h0;
            r_era  <= 32'h0;
        end else if (excp_valid) begin
            r_prmd      <= r_crmd[2:0];
            r_crmd[2:0] <= 3'h0;
            r_era       <= excp_pc;
        end else if (ertn_valid) begin
            r_crmd[2:0] <= r_prmd;
        end else if (w_csr_we) begin
            if (req_csr_addr == A_CRMD) r_crmd <= w_new[8:0];
            if (req_csr_addr == A_PRMD) r_prmd <= w_new[2:0];
            if (req_csr_addr == A_ERA)  r_era  <= w_new;
        end
    end

    // Scratch and TID registers: plain CSR writes only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_save0 <= 32'h0;
            r_save1 <= 32'h0;
            r_save2 <= 32'h0;
            r_save3 <= 32'h0;
            r_tid   <= TID_RST;
        end else if (w_csr_we) begin
            if (req_csr_addr == A_SAVE0) r_save0 <= w_new;
            if (req_csr_addr == A_SAVE1) r_save1 <= w_new;
            if (req_csr_addr == A_SAVE2) r_save2 <= w_new;
            if (req_csr_addr == A_SAVE3) r_save3 <= w_new;
            if (req_csr_addr == A_TID)   r_tid   <= w_new;
        end
    end

    // LLBit/KLO: ERTN clears LLBit unless KLO keeps it (consuming KLO); ops set/clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_llbit <= 1'b0;
            r_klo   <= 1'b0;
        end else if (excp_valid) begin
            r_llbit <= r_llbit;
        end else if (ertn_valid) begin
            if (r_klo) r_klo   <= 1'b0;
            else       r_llbit <= 1'b0;
        end else if (w_accept) begin
            if (w_is_llw) begin
                r_llbit <= 1'b1;
            end else if (w_is_scw) begin
                r_llbit <= 1'b0;
            end else if (w_csr_we && (req_csr_addr == A_LLBCTL)) begin
                if (w_new[1]) r_llbit <= 1'b0;
                r_klo <= w_new[2];
            end
        end
    end

    // Response slot: refill on accept, drop on consume, exception or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_we    <= 1'b0;
            r_resp_rd    <= 5'h0;
            r_resp_data  <= 32'h0;
            r_sc_success <= 1'b0;
        end else if (excp_valid || flush) begin
            r_resp_valid <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_we    <= w_is_csr || w_is_scw;
            r_resp_rd    <= req_rd;
            r_resp_data  <= w_is_csr ? w_rdata : (w_is_scw ? {31'h0, r_llbit} : 32'h0);
            r_sc_success <= w_is_scw && r_llbit;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_we    = r_resp_we;
    assign resp_rd    = r_resp_rd;
    assign resp_data  = r_resp_data;
    assign sc_success = r_sc_success;
    assign llbit      = r_llbit;
    assign crmd_plv   = r_crmd[1:0];
    assign crmd_ie    = r_crmd[2];
    assign era_out    = r_era;

endmodule

// File: tb/tb_csr_llbit_unit.sv
// Directed testbench for csr_llbit_unit with hand-computed expected values.

`ifndef ALU_CSRRD
`define ALU_CSRRD   8'h80
`endif
`ifndef ALU_CSRWR
`define ALU_CSRWR   8'h81
`endif
`ifndef ALU_CSRXCHG
`define ALU_CSRXCHG 8'h82
`endif
`ifndef ALU_LLW
`define ALU_LLW     8'h83
`endif
`ifndef ALU_SCW
`define ALU_SCW     8'h84
`endif

module tb_csr_llbit_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_aluop;
    logic [13:0] req_csr_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_mask;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        sc_success;
    logic        excp_valid;
    logic [31:0] excp_pc;
    logic        ertn_valid;
    logic        flush;
    logic        llbit;
    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic [31:0] era_out;

    int checks;
    int failures;

    csr_llbit_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_aluop    (req_aluop),
        .req_csr_addr (req_csr_addr),
        .req_wdata    (req_wdata),
        .req_mask     (req_mask),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_we      (resp_we),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .sc_success   (sc_success),
        .excp_valid   (excp_valid),
        .excp_pc      (excp_pc),
        .ertn_valid   (ertn_valid),
        .flush        (flush),
        .llbit        (llbit),
        .crmd_plv     (crmd_plv),
        .crmd_ie      (crmd_ie),
        .era_out      (era_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; on return the response of that op is visible.
    task automatic do_op(input logic [7:0] op, input logic [13:0] addr,
                         input logic [31:0] wd, input logic [31:0] mk, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_aluop    = op;
        req_csr_addr = addr;
        req_wdata    = wd;
        req_mask     = mk;
        req_rd       = rd;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic pulse_ertn();
        ertn_valid = 1'b1;
        step();
        ertn_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_aluop = 8'h0;
        req_csr_addr = 14'h0;
        req_wdata = 32'h0;
        req_mask = 32'h0;
        req_rd = 5'h0;
        resp_ready = 1'b1;
        excp_valid = 1'b0;
        excp_pc = 32'h0;
        ertn_valid = 1'b0;
        flush = 1'b0;

        // Reset state
        step();
        step();
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_llbit", {31'h0, llbit}, 32'h0);
        check("rst_plv_ie", {29'h0, crmd_ie, crmd_plv}, 32'h0);
        check("rst_era", era_out, 32'h0);
        rst_n = 1'b1;
        step();

        // CSRRD CRMD, rd=5 -> 0x8 after one cycle
        do_op(`ALU_CSRRD, 14'h0, 32'h0, 32'h0, 5'd5);
        check("rd_crmd_valid", {31'h0, resp_valid}, 32'h1);
        check("rd_crmd_we", {31'h0, resp_we}, 32'h1);
        check("rd_crmd_rd", {27'h0, resp_rd}, 32'd5);
        check("rd_crmd_data", resp_data, 32'h8);

        // CSRWR / CSRXCHG on SAVE0, back to back
        do_op(`ALU_CSRWR, 14'h30, 32'hDEADBEEF, 32'h0, 5'd1);
        check("wr_save0_old", resp_data, 32'h0);
        do_op(`ALU_CSRXCHG, 14'h30, 32'h0000FFFF, 32'h00FF00FF, 5'd2);
        check("xchg_save0_old", resp_data, 32'hDEADBEEF);
        check("xchg_rd", {27'h0, resp_rd}, 32'd2);
        do_op(`ALU_CSRRD, 14'h30, 32'h0, 32'h0, 5'd3);
        check("save0_merged", resp_data, 32'hDE00BEFF);

        // Unimplemented CSR ignores writes; CRMD keeps only bits [8:0]
        do_op(`ALU_CSRWR, 14'h7, 32'h12345678, 32'h0, 5'd1);
        do_op(`ALU_CSRRD, 14'h7, 32'h0, 32'h0, 5'd1);
        check("unimpl_read", resp_data, 32'h0);
        do_op(`ALU_CSRWR, 14'h0, 32'hFFFFFFFF, 32'h0, 5'd1);
        do_op(`ALU_CSRRD, 14'h0, 32'h0, 32'h0, 5'd1);
        check("crmd_mask", resp_data, 32'h1FF);

        // LL.W then two SC.W
        do_op(`ALU_LLW, 14'h0, 32'h0, 32'h0, 5'd6);
        check("llw_we", {31'h0, resp_we}, 32'h0);
        check("llw_llbit", {31'h0, llbit}, 32'h1);
        do_op(`ALU_SCW, 14'h0, 32'h0, 32'h0, 5'd4);
        check("sc1_data", resp_data, 32'h1);
        check("sc1_success", {31'h0, sc_success}, 32'h1);
        check("sc1_we", {31'h0, resp_we}, 32'h1);
        do_op(`ALU_SCW, 14'h0, 32'h0, 32'h0, 5'd4);
        check("sc2_data", resp_data, 32'h0);
        check("sc2_success", {31'h0, sc_success}, 32'h0);
        check("sc2_llbit", {31'h0, llbit}, 32'h0);

        // LLBCTL: WCLLB clears LLBit
        do_op(`ALU_LLW, 14'h0, 32'h0, 32'h0, 5'd6);
        do_op(`ALU_CSRWR, 14'h60, 32'h2, 32'h0, 5'd1);
        check("wcllb_llbit", {31'h0, llbit}, 32'h0);

        // KLO keeps LLBit across one ERTN and is consumed
        do_op(`ALU_LLW, 14'h0, 32'h0, 32'h0, 5'd6);
        do_op(`ALU_CSRWR, 14'h60, 32'h4, 32'h0, 5'd1);
        do_op(`ALU_CSRRD, 14'h60, 32'h0, 32'h0, 5'd1);
        check("llbctl_klo", resp_data, 32'h5);
        pulse_ertn();
        check("klo_ertn_llbit", {31'h0, llbit}, 32'h1);
        do_op(`ALU_CSRRD, 14'h60, 32'h0, 32'h0, 5'd1);
        check("klo_cleared", resp_data, 32'h1);
        do_op(`ALU_LLW, 14'h0, 32'h0, 32'h0, 5'd6);
        pulse_ertn();
        check("ertn_llbit_clr", {31'h0, llbit}, 32'h0);

        // Exception entry and ERTN on CRMD/PRMD/ERA
        do_op(`ALU_CSRWR, 14'h0, 32'h7, 32'h0, 5'd1);
        check("crmd7_plv_ie", {29'h0, crmd_ie, crmd_plv}, 32'h7);
        excp_valid = 1'b1;
        excp_pc = 32'h1C000100;
        step();
        excp_valid = 1'b0;
        check("excp_plv_ie", {29'h0, crmd_ie, crmd_plv}, 32'h0);
        check("excp_era", era_out, 32'h1C000100);
        do_op(`ALU_CSRRD, 14'h1, 32'h0, 32'h0, 5'd1);
        check("excp_prmd", resp_data, 32'h7);
        pulse_ertn();
        check("ertn_plv_ie", {29'h0, crmd_ie, crmd_plv}, 32'h7);

        // Exception and ERTN together: only the exception applies
        excp_valid = 1'b1;
        ertn_valid = 1'b1;
        excp_pc = 32'h0000_2000;
        step();
        excp_valid = 1'b0;
        ertn_valid = 1'b0;
        check("both_plv_ie", {29'h0, crmd_ie, crmd_plv}, 32'h0);
        check("both_era", era_out, 32'h0000_2000);

        // Backpressure: held response stays stable, further ops stalled
        resp_ready = 1'b0;
        do_op(`ALU_CSRRD, 14'h30, 32'h0, 32'h0, 5'd7);
        req_valid = 1'b1;
        req_aluop = `ALU_CSRWR;
        req_csr_addr = 14'h31;
        req_wdata = 32'h1234;
        req_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", {31'h0, req_ready}, 32'h0);
            check("hold_valid", {31'h0, resp_valid}, 32'h1);
            check("hold_data", resp_data, 32'hDE00BEFF);
            check("hold_rd", {27'h0, resp_rd}, 32'd7);
            step();
        end
        flush = 1'b1;
        resp_ready = 1'b1;
        #1;
        check("flush_ready", {31'h0, req_ready}, 32'h0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_valid", {31'h0, resp_valid}, 32'h0);
        do_op(`ALU_CSRRD, 14'h31, 32'h0, 32'h0, 5'd1);
        check("flush_no_write", resp_data, 32'h0);

        // Reset while a response is held
        resp_ready = 1'b0;
        do_op(`ALU_LLW, 14'h0, 32'h0, 32'h0, 5'd6);
        check("pre_rst_valid", {31'h0, resp_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, resp_valid}, 32'h0);
        check("async_rst_llbit", {31'h0, llbit}, 32'h0);
        check("async_rst_era", era_out, 32'h0);
        step();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        step();
        do_op(`ALU_CSRRD, 14'h0, 32'h0, 32'h0, 5'd5);
        check("rst_crmd_again", resp_data, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
